hazard_stall_controller: RTL
============================

Name: hazard_stall_controller

Overview:
- Pipeline sequencer for the 5-stage RV32I core. Decides each cycle whether stages advance, stall, bubble or flush.
- Drives IDEX_control_mux of the decode control unit: 1 passes the decoded control signals, 0 inserts a nop.
- Handles load-use hazards, taken-branch flush and multi-cycle data-memory waits. Keeps saturating performance counters and a sticky memory-timeout flag.

Parameters:
- TIMEOUT, 255, max consecutive MEM_WAIT cycles before mem_timeout sets (1..65535)
- CNT_W, 16, width of the stall and flush counters

Ports:
- clk  in  1  core clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- ifid_opcode  in  7  opcode of the instruction in IF/ID
- ifid_rs1  in  5  rs1 field of IF/ID
- ifid_rs2  in  5  rs2 field of IF/ID
- idex_rd  in  5  rd of the instruction in ID/EX
- idex_memread  in  1  ID/EX instruction is a load
- ex_branch_taken  in  1  branch resolved taken in EX this cycle
- exmem_memreq  in  1  EX/MEM instruction accesses data memory (MemRead or MemWrite)
- dmem_ready  in  1  data memory completes the access this cycle
- pc_write  out  1  PC register load enable
- ifid_write  out  1  IF/ID load enable
- ifid_flush  out  1  IF/ID loads a nop
- IDEX_control_mux  out  1  1 = pass control, 0 = bubble into ID/EX
- pipe_hold  out  1  freezes ID/EX and EX/MEM; MEM/WB loads a bubble
- mem_timeout  out  1  sticky error flag
- stall_count  out  CNT_W  cycles lost to stalls, saturating
- flush_count  out  CNT_W  taken-branch flushes, saturating

Behaviour:
- Reset: state=RUN, wait counter=0, mem_timeout=0, stall_count=0, flush_count=0. Reset mid-MEM_WAIT aborts the wait immediately.
- During reset, outputs take their RUN-state values from the inputs.
- Source-register usage by ifid_opcode:
  - rs1 is used by 0110011, 0000011, 0100011, 1100011 and 0010011.
  - rs2 is used by 0110011, 0100011 and 1100011.
  - Any other opcode uses neither.
- Load-use hazard (luh) = idex_memread and idex_rd != 0 and (idex_rd == a used rs1 or a used rs2). Combinational.
- Memory miss (miss) = exmem_memreq and !dmem_ready.
- FSM states: RUN and MEM_WAIT.
- RUN, priority order (only the highest applies):
  1. miss: pc_write=0, ifid_write=0, pipe_hold=1, IDEX_control_mux=1. Next state MEM_WAIT. Wait counter=1. ex_branch_taken is ignored this cycle; the MEM stage re-presents it.
  2. ex_branch_taken: pc_write=1, ifid_flush=1, IDEX_control_mux=0, ifid_write=1. flush_count+1. luh is ignored, because the instruction is flushed.
  3. luh: pc_write=0, ifid_write=0, IDEX_control_mux=0. stall_count+1. Exactly one bubble per load-use pair.
  4. Otherwise: pc_write=1, ifid_write=1, ifid_flush=0, IDEX_control_mux=1, pipe_hold=0.
- MEM_WAIT:
  - Outputs are the same as the RUN miss case. stall_count+1 every cycle.
  - When dmem_ready=1, outputs revert to the RUN rules in that same cycle and next state is RUN. Zero extra latency after ready.
  - The wait counter increments every cycle. When it reaches TIMEOUT, mem_timeout sets and stays set until reset. The stall continues, so the controller never unblocks without ready.
- Counters: stall_count and flush_count saturate at all-ones. Neither ever wraps.
- Every output except the counters and mem_timeout is combinational from state and inputs. There is no added latency.

Decomposition:
- Shared package core_pkg, holding:
  - opcode constants OP_RTYPE=0110011, OP_LOAD=0000011, OP_STORE=0100011, OP_BRANCH=1100011, OP_ADDI=0010011.
  - state enum {RUN, MEM_WAIT}.
  - These constants are also consumed by the control unit.
- One sub-module: sat_counter, parameterised width with increment enable and saturation. It is instantiated for stall_count and flush_count.

Test Plan:
- Load-use: idex_memread=1, idex_rd=5, ifid_opcode=0110011, ifid_rs2=5 → one cycle with pc_write=0, ifid_write=0, IDEX_control_mux=0; stall_count 0→1; next cycle all enables 1.
- x0 and unused rs2: idex_rd=0 with rs1=0 → no stall. Then idex_rd=7, ifid_opcode=0010011, ifid_rs2=7 → no stall, because addi does not use rs2.
- Branch beats hazard: ex_branch_taken=1 plus an active luh → ifid_flush=1, IDEX_control_mux=0, pc_write=1; flush_count=1; stall_count unchanged.
- Memory wait: exmem_memreq=1, dmem_ready=0 for 3 cycles, then 1 → pipe_hold=1 and pc_write=0 for 3 cycles; stall_count=3; RUN resumes and pipe_hold=0 in the ready cycle.
- Timeout: TIMEOUT=4, dmem_ready held at 0 → mem_timeout=1 after the 4th wait cycle; it stays 1 after ready returns; a mid-wait rst_n pulse clears it and returns to RUN.
- Saturation: CNT_W=4, 20 consecutive luh cycles → stall_count reaches 15 and stays at 15.

Source files
------------

// File: rtl/core_pkg.sv
// Shared RV32I core definitions: opcode constants, pipeline sequencer states,
// and helpers that tell which source registers an opcode reads.
package core_pkg;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_ADDI   = 7'b0010011;

  localparam int unsigned WAIT_W = 16;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_e;

  function automatic logic uses_rs1(input logic [6:0] op);
    logic used;
    case (op)
      OP_RTYPE, OP_LOAD, OP_STORE, OP_BRANCH, OP_ADDI: used = 1'b1;
      default:                                         used = 1'b0;
    endcase
    return used;
  endfunction

  function automatic logic uses_rs2(input logic [6:0] op);
    logic used;
    case (op)
      OP_RTYPE, OP_STORE, OP_BRANCH: used = 1'b1;
      default:                       used = 1'b0;
    endcase
    return used;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter with increment enable that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (inc && (count_reg != {W{1'b1}})) begin
      count_reg <= count_reg + W'(1);
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/hazard_stall_controller.sv
// Pipeline sequencer for the 5-stage core: load-use bubbles, taken-branch
// flushes and data-memory wait stalls, plus stall/flush counters and a timeout flag.
module hazard_stall_controller
  import core_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       ifid_opcode,
  input  logic [4:0]       ifid_rs1,
  input  logic [4:0]       ifid_rs2,
  input  logic [4:0]       idex_rd,
  input  logic             idex_memread,
  input  logic             ex_branch_taken,
  input  logic             exmem_memreq,
  input  logic             dmem_ready,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             IDEX_control_mux,
  output logic             pipe_hold,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam logic [WAIT_W-1:0] TIMEOUT_VAL = WAIT_W'(TIMEOUT);

  state_e            state_reg, state_next;
  logic [WAIT_W-1:0] wait_reg, wait_next;
  logic              timeout_reg, timeout_set;
  logic              stall_inc, flush_inc;
  logic              luh, miss, mem_hold;
  logic              rs1_hit, rs2_hit;

  assign rs1_hit = uses_rs1(ifid_opcode) && (idex_rd == ifid_rs1);
  assign rs2_hit = uses_rs2(ifid_opcode) && (idex_rd == ifid_rs2);
  assign luh     = idex_memread && (idex_rd != 5'd0) && (rs1_hit || rs2_hit);
  assign miss    = exmem_memreq && !dmem_ready;

  // Once waiting, only dmem_ready releases the hold, whatever exmem_memreq does.
  always_comb begin
    mem_hold = 1'b0;
    unique case (state_reg)
      RUN:      mem_hold = miss;
      MEM_WAIT: mem_hold = !dmem_ready;
      default:  mem_hold = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= RUN;
      wait_reg    <= '0;
      timeout_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      wait_reg  <= wait_next;
      if (timeout_set) begin
        timeout_reg <= 1'b1;
      end
    end
  end

  always_comb begin
    pc_write         = 1'b1;
    ifid_write       = 1'b1;
    ifid_flush       = 1'b0;
    IDEX_control_mux = 1'b1;
    pipe_hold        = 1'b0;
    state_next       = RUN;
    wait_next        = '0;
    stall_inc        = 1'b0;
    flush_inc        = 1'b0;
    timeout_set      = 1'b0;

    if (mem_hold) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      pipe_hold  = 1'b1;
      state_next = MEM_WAIT;
      stall_inc  = 1'b1;
      // The miss cycle itself counts as the first wait cycle; the count
      // parks at TIMEOUT so a very long wait cannot wrap it back below.
      if (state_reg == RUN) begin
        wait_next = WAIT_W'(1);
      end else if (wait_reg < TIMEOUT_VAL) begin
        wait_next = wait_reg + WAIT_W'(1);
      end else begin
        wait_next = wait_reg;
      end
      timeout_set = (wait_next >= TIMEOUT_VAL);
    end else if (ex_branch_taken) begin
      ifid_flush       = 1'b1;
      IDEX_control_mux = 1'b0;
      flush_inc        = 1'b1;
    end else if (luh) begin
      pc_write         = 1'b0;
      ifid_write       = 1'b0;
      IDEX_control_mux = 1'b0;
      stall_inc        = 1'b1;
    end
  end

  assign mem_timeout = timeout_reg;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stall_inc),
    .count (stall_count)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (flush_inc),
    .count (flush_count)
  );

endmodule
